// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the instruction ROM and its byte-stream loader.
// Bus widths match the core's instruction and instruction-address buses.
package inst_rom_loader_pkg;

  localparam int INST_BUS_W      = 32;
  localparam int INST_ADDR_BUS_W = 32;

  localparam logic [INST_BUS_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_RUN
  } state_t;

endpackage

// File: rtl/inst_rom_mem.sv
// Instruction word store: single-port synchronous write, asynchronous read.
// Write lands on the clock edge; the read port is zero latency and never stalls.
module inst_rom_mem
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [INST_BUS_W-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [INST_BUS_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Contents are deliberately not reset; readability is gated by the loader.
  logic [INST_BUS_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM with a byte-stream program loader; holds the core in reset while loading.
// Fetch is combinational (zero latency); the loader accepts one byte per cycle in HDR/DATA.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce_i,
  input  logic [INST_ADDR_BUS_W-1:0] addr_i,
  output logic [INST_BUS_W-1:0]      inst_o,
  input  logic                       load_start_i,
  input  logic                       load_valid_i,
  input  logic [7:0]                 load_byte_i,
  output logic                       load_ready_o,
  output logic                       load_done_o,
  output logic                       load_err_o,
  output logic                       cpu_rst_o,
  output logic [ADDR_WIDTH:0]        words_loaded_o
);

  localparam logic [31:0] DEPTH    = 32'(1) << ADDR_WIDTH;
  localparam logic [7:0]  HDR_LAST = 8'(LEN_WIDTH / 8 - 1);

  state_t                state_q, state_d;
  logic [7:0]            byte_cnt_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  len_next;
  logic [23:0]           data_q;
  logic [ADDR_WIDTH:0]   words_loaded_q;
  logic                  done_q, done_d;
  logic                  err_q, err_set;
  logic                  accept;
  logic                  hdr_last;
  logic                  word_last;
  logic [INST_BUS_W-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [INST_BUS_W-1:0] rd_data;
  logic                  fetch_ok;
  logic                  unused_addr_bits;

  assign load_ready_o = (state_q == ST_HDR) || (state_q == ST_DATA);
  // A start pulse wins over any byte offered in the same cycle.
  assign accept    = load_valid_i && load_ready_o && !load_start_i;
  assign hdr_last  = accept && (state_q == ST_HDR) && (byte_cnt_q == HDR_LAST);
  assign word_last = accept && (state_q == ST_DATA) && (byte_cnt_q == 8'd3);
  assign len_next  = LEN_WIDTH'({len_q, load_byte_i});
  assign wr_data   = {data_q, load_byte_i};

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_set = 1'b0;
    if (load_start_i) begin
      state_d = ST_HDR;
    end else begin
      case (state_q)
        ST_HDR: begin
          if (hdr_last) begin
            if (len_next == '0) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else if (32'(len_next) > DEPTH) begin
              state_d = ST_IDLE;
              err_set = 1'b1;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_last && (32'(words_loaded_q) + 32'd1 == 32'(len_q))) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q     <= '0;
      len_q          <= '0;
      data_q         <= '0;
      words_loaded_q <= '0;
      err_q          <= 1'b0;
    end else if (load_start_i) begin
      byte_cnt_q     <= '0;
      len_q          <= '0;
      words_loaded_q <= '0;
      err_q          <= 1'b0;
    end else begin
      if (accept && (state_q == ST_HDR)) begin
        len_q      <= len_next;
        byte_cnt_q <= hdr_last ? 8'd0 : byte_cnt_q + 8'd1;
      end
      if (accept && (state_q == ST_DATA)) begin
        data_q     <= {data_q[15:0], load_byte_i};
        byte_cnt_q <= word_last ? 8'd0 : byte_cnt_q + 8'd1;
      end
      if (word_last) words_loaded_q <= words_loaded_q + 1'b1;
      if (err_set) err_q <= 1'b1;
    end
  end

  // The word count doubles as the write pointer: the next free slot.
  inst_rom_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk   (clk),
    .we    (word_last),
    .waddr (words_loaded_q[ADDR_WIDTH-1:0]),
    .wdata (wr_data),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  assign rd_idx           = addr_i[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^addr_i[1:0];
  assign fetch_ok = (state_q == ST_RUN) && ce_i
                 && (addr_i[INST_ADDR_BUS_W-1:ADDR_WIDTH+2] == '0)
                 && ({1'b0, rd_idx} < words_loaded_q);

  assign inst_o         = fetch_ok ? rd_data : NOP_INST;
  assign cpu_rst_o      = (state_q != ST_RUN);
  assign load_done_o    = done_q;
  assign load_err_o     = err_q;
  assign words_loaded_o = words_loaded_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: stimulus queues expectations, a negedge monitor checks them.
module tb_inst_rom_loader;

  localparam int AW = 10;

  localparam int K_INST  = 0;
  localparam int K_CRST  = 1;
  localparam int K_RDY   = 2;
  localparam int K_ERR   = 3;
  localparam int K_WORDS = 4;
  localparam int K_DONE  = 5;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce_i = 1'b1;
  logic [31:0]   addr_i = '0;
  logic [31:0]   inst_o;
  logic          load_start_i = 1'b0;
  logic          load_valid_i = 1'b0;
  logic [7:0]    load_byte_i = '0;
  logic          load_ready_o;
  logic          load_done_o;
  logic          load_err_o;
  logic          cpu_rst_o;
  logic [AW:0]   words_loaded_o;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic          probe_vld = 1'b0;
  exp_t          chk_q[$];
  logic [31:0]   done_q[$];

  always #5 clk = ~clk;

  inst_rom_loader #(.ADDR_WIDTH(AW), .LEN_WIDTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .ce_i           (ce_i),
    .addr_i         (addr_i),
    .inst_o         (inst_o),
    .load_start_i   (load_start_i),
    .load_valid_i   (load_valid_i),
    .load_byte_i    (load_byte_i),
    .load_ready_o   (load_ready_o),
    .load_done_o    (load_done_o),
    .load_err_o     (load_err_o),
    .cpu_rst_o      (cpu_rst_o),
    .words_loaded_o (words_loaded_o)
  );

  // Monitor: drains pending expectations on a probe cycle and checks every done pulse.
  exp_t        mon_e;
  logic [31:0] mon_act;
  logic [31:0] mon_exp;
  always @(negedge clk) begin
    if (probe_vld) begin
      while (chk_q.size() > 0) begin
        mon_e = chk_q.pop_front();
        case (mon_e.kind)
          K_INST:  mon_act = inst_o;
          K_CRST:  mon_act = {31'b0, cpu_rst_o};
          K_RDY:   mon_act = {31'b0, load_ready_o};
          K_ERR:   mon_act = {31'b0, load_err_o};
          K_WORDS: mon_act = 32'(words_loaded_o);
          default: mon_act = {31'b0, load_done_o};
        endcase
        n_checks++;
        if (mon_act !== mon_e.exp) begin
          n_fail++;
          $display("FAIL %s actual=%h expected=%h", mon_e.name, mon_act, mon_e.exp);
        end
      end
    end
    if (load_done_o === 1'b1) begin
      n_checks++;
      if (done_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        mon_exp = done_q.pop_front();
        if (32'(words_loaded_o) !== mon_exp || cpu_rst_o !== 1'b0) begin
          n_fail++;
          $display("FAIL done_words actual=%0d/cpu_rst=%b expected=%0d/cpu_rst=0",
                   words_loaded_o, cpu_rst_o, mon_exp);
        end
      end
    end
  end

  task automatic expect_val(input int kind, input logic [31:0] v, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = name;
    chk_q.push_back(e);
  endtask

  task automatic sample();
    probe_vld = 1'b1;
    @(posedge clk); #1;
    probe_vld = 1'b0;
  endtask

  task automatic check1(input int kind, input logic [31:0] v, input string name);
    expect_val(kind, v, name);
    sample();
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] v, input string name);
    addr_i = a;
    check1(K_INST, v, name);
  endtask

  task automatic start_load();
    load_start_i = 1'b1;
    @(posedge clk); #1;
    load_start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    load_valid_i = 1'b1;
    load_byte_i  = b;
    t = 0;
    while (!load_ready_o && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!load_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_accept_timeout actual=ready_low expected=ready_high");
    end
    @(posedge clk); #1;
    load_valid_i = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bs[$]);
    for (int i = 0; i < bs.size(); i++) send_byte(bs[i], i % 3);
  endtask

  logic [7:0] seq[$];

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    expect_val(K_INST,  32'h0, "rst_inst");
    expect_val(K_CRST,  32'h1, "rst_cpu_rst");
    expect_val(K_RDY,   32'h0, "rst_ready");
    expect_val(K_ERR,   32'h0, "rst_err");
    expect_val(K_WORDS, 32'h0, "rst_words");
    expect_val(K_DONE,  32'h0, "rst_done");
    sample();

    // Two-word program
    start_load();
    expect_val(K_RDY,  32'h1, "hdr_ready");
    check1(K_CRST, 32'h1, "hdr_cpu_rst");
    done_q.push_back(32'd2);
    seq = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h05, 8'h34, 8'h02, 8'h00, 8'h07};
    send_bytes(seq);
    check1(K_CRST,  32'h0, "run_cpu_rst");
    check1(K_WORDS, 32'd2, "run_words");
    check1(K_DONE,  32'h0, "done_one_cycle");
    check1(K_RDY,   32'h0, "run_ready");
    fetch(32'h0, 32'h3401_0005, "fetch_0");
    fetch(32'h4, 32'h3402_0007, "fetch_4");
    fetch(32'h8, 32'h0,         "fetch_8_unloaded");
    fetch(32'h5, 32'h3402_0007, "fetch_5_lowbits");
    fetch(32'h1000_0000, 32'h0, "fetch_high_addr");
    ce_i = 1'b0;
    fetch(32'h0, 32'h0, "fetch_ce_low");
    ce_i = 1'b1;

    // Oversized header: 1025 words
    start_load();
    seq = '{8'h04, 8'h01};
    send_bytes(seq);
    expect_val(K_ERR,   32'h1, "err_set");
    expect_val(K_CRST,  32'h1, "err_cpu_rst");
    expect_val(K_RDY,   32'h0, "err_idle_ready");
    expect_val(K_WORDS, 32'h0, "err_words");
    fetch(32'h0, 32'h0, "err_fetch");

    // Empty program
    start_load();
    check1(K_ERR, 32'h0, "restart_clears_err");
    done_q.push_back(32'd0);
    seq = '{8'h00, 8'h00};
    send_bytes(seq);
    check1(K_CRST,  32'h0, "empty_cpu_rst");
    check1(K_WORDS, 32'h0, "empty_words");
    fetch(32'h0, 32'h0, "empty_fetch_0");
    fetch(32'h4, 32'h0, "empty_fetch_4");

    // Restart in DATA with a colliding byte
    start_load();
    seq = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send_bytes(seq);
    load_start_i = 1'b1;
    load_valid_i = 1'b1;
    load_byte_i  = 8'hCC;
    @(posedge clk); #1;
    load_start_i = 1'b0;
    load_valid_i = 1'b0;
    done_q.push_back(32'd1);
    seq = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_bytes(seq);
    check1(K_WORDS, 32'd1, "restart_words");
    fetch(32'h0, 32'h1122_3344, "restart_fetch_0");
    fetch(32'h4, 32'h0,         "restart_fetch_4");

    // Asynchronous reset in RUN while fetching
    addr_i = 32'h0;
    rst = 1'b1;
    expect_val(K_INST,  32'h0, "arst_inst");
    expect_val(K_CRST,  32'h1, "arst_cpu_rst");
    expect_val(K_WORDS, 32'h0, "arst_words");
    sample();
    rst = 1'b0;
    check1(K_RDY, 32'h0, "arst_idle_ready");
    start_load();
    done_q.push_back(32'd1);
    seq = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_bytes(seq);
    fetch(32'h0, 32'hDEAD_BEEF, "reload_fetch_0");
    fetch(32'h4, 32'h0,         "reload_fetch_4");

    repeat (2) @(posedge clk);
    n_checks++;
    if (done_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_done actual=%0d_pending expected=0", done_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
